// File: rtl/dtcm_ldst_slv.sv
// Data tightly-coupled memory: responder for load/store requests.
// Byte-strobed word writes and word reads, answered in order through a small response queue.
module dtcm_ldst_slv #(
  parameter int unsigned   AW          = 32,
  parameter int unsigned   XLEN        = 32,
  parameter logic [AW-1:0] BASE_ADDR   = 32'h8000_0000,
  parameter int unsigned   DEPTH_WORDS = 1024,
  parameter int unsigned   RSP_DEPTH   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ldst_req_vld,
  output logic              ldst_req_rdy,
  input  logic [AW-1:0]     ldst_req_addr,
  input  logic              ldst_req_st,
  input  logic [XLEN-1:0]   ldst_req_data,
  input  logic [XLEN/8-1:0] ldst_req_strobe,
  output logic              ldst_rsp_vld,
  input  logic              ldst_rsp_rdy,
  output logic [XLEN-1:0]   ldst_rsp_data,
  output logic              ldst_rsp_ok
);

  localparam int unsigned SW = XLEN / 8;
  localparam int unsigned IW = $clog2(DEPTH_WORDS);
  localparam int unsigned CW = $clog2(RSP_DEPTH + 1);
  localparam int unsigned QD = RSP_DEPTH - 1;
  localparam logic [AW-1:0] SPAN = AW'(DEPTH_WORDS * 4);

  typedef struct packed {
    logic [XLEN-1:0] data;
    logic            ok;
  } rsp_t;

  logic [XLEN-1:0] mem [DEPTH_WORDS];

  logic [CW-1:0] cnt_q, cnt_d;
  logic          rdy_q, rdy_d;
  logic          vld_q, vld_d;
  rsp_t          out_q, out_d;
  rsp_t          q_q [QD];
  rsp_t          q_d [QD];

  logic [AW-1:0] off_c;
  logic          hit_c;
  logic [IW-1:0] idx_c;
  logic          req_fire_c, rsp_fire_c, we_c;
  rsp_t          new_c;
  logic [CW-1:0] q_cnt_c, wr_idx_c;
  logic          slot_free_c, pop_c, push_c;

  // Address decode and response for the request presented this cycle
  always_comb begin
    off_c      = ldst_req_addr - BASE_ADDR;
    hit_c      = (ldst_req_addr >= BASE_ADDR) && (off_c < SPAN) && (ldst_req_addr[1:0] == 2'b00);
    idx_c      = off_c[IW+1:2];
    req_fire_c = ldst_req_vld && rdy_q;
    rsp_fire_c = vld_q && ldst_rsp_rdy;
    we_c       = req_fire_c && ldst_req_st && hit_c && !rst;
    new_c.ok   = hit_c;
    new_c.data = (hit_c && !ldst_req_st) ? mem[idx_c] : '0;
  end

  // Output slot is the queue head; the backing queue holds the rest in order
  always_comb begin
    cnt_d = cnt_q;
    rdy_d = rdy_q;
    vld_d = vld_q;
    out_d = out_q;
    q_d   = q_q;

    q_cnt_c     = cnt_q - CW'(vld_q);
    slot_free_c = !vld_q || rsp_fire_c;
    pop_c       = slot_free_c && (q_cnt_c != '0);
    push_c      = req_fire_c && !(slot_free_c && (q_cnt_c == '0));
    wr_idx_c    = pop_c ? (q_cnt_c - CW'(1)) : q_cnt_c;

    if (slot_free_c) begin
      if (q_cnt_c != '0) begin
        out_d = q_q[0];
        vld_d = 1'b1;
      end else if (req_fire_c) begin
        out_d = new_c;
        vld_d = 1'b1;
      end else begin
        out_d = '0;
        vld_d = 1'b0;
      end
    end

    if (pop_c) begin
      for (int i = 0; i < int'(QD) - 1; i++) q_d[i] = q_q[i+1];
    end
    for (int i = 0; i < int'(QD); i++) begin
      if (push_c && (CW'(i) == wr_idx_c)) q_d[i] = new_c;
    end

    cnt_d = cnt_q + CW'(req_fire_c) - CW'(rsp_fire_c);
    rdy_d = (cnt_d < CW'(RSP_DEPTH));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      rdy_q <= 1'b1;
      vld_q <= 1'b0;
      out_q <= '0;
      for (int i = 0; i < int'(QD); i++) q_q[i] <= '0;
    end else begin
      cnt_q <= cnt_d;
      rdy_q <= rdy_d;
      vld_q <= vld_d;
      out_q <= out_d;
      q_q   <= q_d;
    end
  end

  // Storage array is intentionally not reset
  always_ff @(posedge clk) begin
    if (we_c) begin
      for (int i = 0; i < int'(SW); i++) begin
        if (ldst_req_strobe[i]) mem[idx_c][8*i +: 8] <= ldst_req_data[8*i +: 8];
      end
    end
  end

  assign ldst_req_rdy  = rdy_q;
  assign ldst_rsp_vld  = vld_q;
  assign ldst_rsp_data = out_q.data;
  assign ldst_rsp_ok   = out_q.ok;

  a_cnt_max: assert property (@(posedge clk) disable iff (rst) cnt_q <= CW'(RSP_DEPTH));
  a_no_rsp_empty: assert property (@(posedge clk) disable iff (rst) !(rsp_fire_c && (cnt_q == '0)));
  a_rsp_stable: assert property (@(posedge clk) disable iff (rst)
    (vld_q && !ldst_rsp_rdy) |=> (vld_q && $stable(out_q)));

endmodule
